pulse_peak_finder: RTL and testbench

- Downstream neighbour of the shaping filter.
- Consumes the filter's 16-bit shaped output every clock and detects pulses that cross a programmable threshold.
- Reports each pulse's maximum amplitude and the timestamp of that maximum through a valid/ack output register.
- Feeds the event buffer or readout logic.

---
 rtl/pulse_peak_finder.sv | 163 ++++++++++++++++
 tb/tb_pulse_peak_finder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_peak_finder.sv
// Threshold pulse detector: reports each pulse's peak amplitude and the timestamp of its first occurrence.
// Optional pile-up abort (length limit) is enabled by defining PULSE_PEAK_FINDER_PILEUP_EN.
module pulse_peak_finder #(
   parameter int WIDTH    = 16,
   parameter int TS_WIDTH = 16,
   parameter int HOLDOFF  = 8,
   parameter int MAX_LEN  = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] in,
   input  logic signed [WIDTH-1:0] threshold,
   output logic signed [WIDTH-1:0] out_amp,
   output logic [TS_WIDTH-1:0]     out_time,
   output logic                    out_valid,
   input  logic                    out_ack,
   output logic                    busy,
   output logic [7:0]              lost_cnt,
   output logic [7:0]              pileup_cnt
);
   localparam int HW = $clog2(HOLDOFF + 2);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF);

   if (MAX_LEN < 1) begin : g_bad_max_len
      $error("pulse_peak_finder: MAX_LEN must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, RISE, HOLD} state_t;

   state_t                  state, state_nxt;
   logic [TS_WIDTH-1:0]     ts;
   logic signed [WIDTH-1:0] max_val, max_nxt;
   logic [TS_WIDTH-1:0]     max_ts, max_ts_nxt;
   logic [HW-1:0]           hold_cnt, hold_nxt;
   logic                    above;
   logic                    emit;

`ifdef PULSE_PEAK_FINDER_PILEUP_EN
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] LEN_LAST = LW'(MAX_LEN);

   logic [LW-1:0] len, len_nxt;
   logic          seen_low, seen_low_nxt;
   logic          pileup_hit;
`endif

   assign above = in > threshold;
   assign busy  = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      max_nxt    = max_val;
      max_ts_nxt = max_ts;
      hold_nxt   = hold_cnt;
      emit       = 1'b0;
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
      len_nxt      = len;
      seen_low_nxt = seen_low;
      pileup_hit   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (above) begin
               state_nxt  = RISE;
               max_nxt    = in;
               max_ts_nxt = ts;
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
               len_nxt    = LW'(1);
`endif
            end
         end
         RISE: begin
            if (!above) begin
               // The ending sample never competes for the peak.
               emit     = 1'b1;
               hold_nxt = '0;
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
               seen_low_nxt = 1'b1;
`endif
               if (HOLDOFF == 0) state_nxt = IDLE;
               else              state_nxt = HOLD;
            end
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
            else if (len == LEN_LAST) begin
               pileup_hit   = 1'b1;
               hold_nxt     = '0;
               seen_low_nxt = 1'b0;
               state_nxt    = HOLD;
            end
`endif
            else begin
               if (in > max_val) begin
                  max_nxt    = in;
                  max_ts_nxt = ts;
               end
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
               len_nxt = len + 1'b1;
`endif
            end
         end
         HOLD: begin
            hold_nxt = (hold_cnt < HOLD_LAST) ? hold_cnt + 1'b1 : hold_cnt;
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
            // After an abort, wait for the long pulse to actually fall so it is not split.
            if (!above) seen_low_nxt = 1'b1;
            if ((hold_nxt == HOLD_LAST) && (seen_low || !above)) state_nxt = IDLE;
`else
            if (hold_nxt == HOLD_LAST) state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ts       <= '0;
         max_val  <= '0;
         max_ts   <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ts       <= ts + 1'b1;
         max_val  <= max_nxt;
         max_ts   <= max_ts_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_amp   <= '0;
         out_time  <= '0;
         out_valid <= 1'b0;
         lost_cnt  <= '0;
      end else if (emit && (!out_valid || out_ack)) begin
         out_amp   <= max_val;
         out_time  <= max_ts;
         out_valid <= 1'b1;
      end else begin
         if (emit && (lost_cnt != 8'hFF)) lost_cnt <= lost_cnt + 1'b1;
         if (out_ack) out_valid <= 1'b0;
      end
   end

`ifdef PULSE_PEAK_FINDER_PILEUP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len        <= '0;
         seen_low   <= 1'b0;
         pileup_cnt <= '0;
      end else begin
         len      <= len_nxt;
         seen_low <= seen_low_nxt;
         if (pileup_hit && (pileup_cnt != 8'hFF)) pileup_cnt <= pileup_cnt + 1'b1;
      end
   end
`else
   assign pileup_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_peak_finder.sv
// Randomized and directed bench for pulse_peak_finder against a pulse-level reference model.
module tb_pulse_peak_finder;
   localparam int HOLD = 8;
   localparam int MAXL = 64;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] in_s, thr_s;
   logic signed [15:0] out_amp;
   logic [15:0]        out_time;
   logic               out_valid, ack_s, busy;
   logic [7:0]         lost_cnt, pileup_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // reference model: pulse tracking plus report register
   int m_ts, m_pk, m_pk_t, m_len, m_dead;
   bit m_in_pulse, m_need_low;
   bit m_valid;
   int m_amp, m_time, m_lost, m_pile;

   int seq[$];
   int rep_t[$];

   pulse_peak_finder #(.WIDTH(16), .TS_WIDTH(16), .HOLDOFF(HOLD), .MAX_LEN(MAXL)) dut (
      .clk(clk), .reset(reset), .in(in_s), .threshold(thr_s),
      .out_amp(out_amp), .out_time(out_time), .out_valid(out_valid), .out_ack(ack_s),
      .busy(busy), .lost_cnt(lost_cnt), .pileup_cnt(pileup_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ts = 0; m_pk = 0; m_pk_t = 0; m_len = 0; m_dead = 0;
      m_in_pulse = 0; m_need_low = 0;
      m_valid = 0; m_amp = 0; m_time = 0; m_lost = 0; m_pile = 0;
   endtask

   task automatic model_edge();
      bit above;
      bit emit;
      above = (int'(in_s) > int'(thr_s));
      emit  = 0;
      if (m_dead > 0 || m_need_low) begin
         if (m_dead > 0) m_dead--;
         if (!above) m_need_low = 0;
      end else if (m_in_pulse) begin
         if (!above) begin
            emit = 1; m_in_pulse = 0; m_dead = HOLD;
         end
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
         else if (m_len == MAXL) begin
            m_in_pulse = 0; m_dead = HOLD; m_need_low = 1;
            if (m_pile < 255) m_pile++;
         end
`endif
         else begin
            if (int'(in_s) > m_pk) begin m_pk = int'(in_s); m_pk_t = m_ts; end
            m_len++;
         end
      end else if (above) begin
         m_in_pulse = 1; m_pk = int'(in_s); m_pk_t = m_ts; m_len = 1;
      end
      if (emit) begin
         if (!m_valid || ack_s) begin
            m_valid = 1; m_amp = m_pk; m_time = m_pk_t;
         end else if (m_lost < 255) m_lost++;
      end else if (ack_s) m_valid = 0;
      m_ts = (m_ts + 1) % 65536;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid",  int'(out_valid),  int'(m_valid));
         check("amp",    int'(out_amp),    m_amp);
         check("time",   int'(out_time),   m_time);
         check("busy",   int'(busy),       int'(m_in_pulse || m_dead > 0 || m_need_low));
         check("lost",   int'(lost_cnt),   m_lost);
         check("pileup", int'(pileup_cnt), m_pile);
      end
   end

   task automatic step(input int v, input int thr, input bit ack);
      in_s  = 16'(v);
      thr_s = 16'(thr);
      ack_s = ack;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("rst_async_valid", int'(out_valid), 0);
      check("rst_async_busy",  int'(busy),      0);
      check("rst_async_amp",   int'(out_amp),   0);
      check("rst_async_time",  int'(out_time),  0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_seq(input int thr, input bit ack);
      rep_t.delete();
      foreach (seq[i]) begin
         step(seq[i], thr, ack);
         if (out_valid) rep_t.push_back(int'(out_time));
      end
   endtask

   initial begin
      int t1[10];
      int thr;
      t1 = '{0, 0, 50, 150, 300, 420, 410, 200, 90, 0};
      reset = 1'b0; in_s = '0; thr_s = '0; ack_s = 1'b0;
      model_reset();
      #1 reset = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_valid", int'(out_valid), 0);
      check("reset_busy",  int'(busy),      0);
      check("reset_lost",  int'(lost_cnt),  0);
      reset = 1'b0;

      // basic pulse
      for (int i = 0; i < 10; i++) begin
         step(t1[i], 100, 1'b0);
         if (i == 2) check("t1_busy_ts2", int'(busy), 0);
         if (i == 3) check("t1_busy_ts3", int'(busy), 1);
         if (i == 8) begin
            check("t1_valid", int'(out_valid), 1);
            check("t1_amp",   int'(out_amp),   420);
            check("t1_time",  int'(out_time),  5);
            check("t1_lost",  int'(lost_cnt),  0);
         end
      end
      repeat (10) step(0, 100, 1'b0);
      step(0, 100, 1'b1);
      check("t1_acked", int'(out_valid), 0);

      // flat top keeps earliest maximum
      do_reset();
      seq.delete();
      foreach (t1[i]) if (i < 5) seq.push_back(0);
      seq[0] = 5; seq[1] = 80; seq[2] = 80; seq[3] = 80; seq[4] = 3;
      foreach (seq[i]) step(seq[i], 10, 1'b0);
      check("flat_valid", int'(out_valid), 1);
      check("flat_amp",   int'(out_amp),   80);
      check("flat_time",  int'(out_time),  1);

      // second pulse inside holdoff is ignored
      do_reset();
      seq.delete();
      seq.push_back(200);
      repeat (4) seq.push_back(0);
      seq.push_back(300);
      repeat (20) seq.push_back(0);
      run_seq(100, 1'b1);
      check("sep4_reports", rep_t.size(), 1);
      if (rep_t.size() >= 1) check("sep4_time", rep_t[0], 0);

      // pulse after holdoff is reported
      do_reset();
      seq.delete();
      seq.push_back(200);
      repeat (12) seq.push_back(0);
      seq.push_back(300);
      repeat (12) seq.push_back(0);
      run_seq(100, 1'b1);
      check("sep12_reports", rep_t.size(), 2);
      if (rep_t.size() >= 2) check("sep12_time2", rep_t[1], 13);

      // lost report, then ack coinciding with emit
      do_reset();
      step(200, 100, 1'b0);
      step(0, 100, 1'b0);
      repeat (8) step(0, 100, 1'b0);
      step(300, 100, 1'b0);
      step(0, 100, 1'b0);
      check("lost_amp",  int'(out_amp),  200);
      check("lost_time", int'(out_time), 0);
      check("lost_cnt1", int'(lost_cnt), 1);
      repeat (8) step(0, 100, 1'b0);
      step(400, 100, 1'b0);
      step(0, 100, 1'b1);
      check("ackemit_valid", int'(out_valid), 1);
      check("ackemit_amp",   int'(out_amp),   400);
      check("ackemit_time",  int'(out_time),  20);
      check("ackemit_lost",  int'(lost_cnt),  1);

      // signed threshold, then async reset mid-pulse
      do_reset();
      step(-50, -20, 1'b0);
      step(-10, -20, 1'b0);
      step(-30, -20, 1'b0);
      check("neg_valid", int'(out_valid), 1);
      check("neg_amp",   int'(out_amp),   -10);
      check("neg_time",  int'(out_time),  1);
      repeat (10) step(-50, -20, 1'b0);
      step(0, -20, 1'b0);
      check("neg_rise_busy", int'(busy), 1);
      do_reset();
      repeat (5) step(-50, -20, 1'b0);
      check("after_rst_valid", int'(out_valid), 0);

      // long pulse
      do_reset();
      repeat (100) step(500, 100, 1'b0);
      check("long_busy_high", int'(busy), 1);
      step(0, 100, 1'b0);
`ifdef PULSE_PEAK_FINDER_PILEUP_EN
      check("long_valid",  int'(out_valid),  0);
      check("long_pileup", int'(pileup_cnt), 1);
      check("long_idle",   int'(busy),       0);
`else
      check("long_valid",  int'(out_valid),  1);
      check("long_amp",    int'(out_amp),    500);
      check("long_time",   int'(out_time),   0);
      check("long_pileup", int'(pileup_cnt), 0);
`endif

      // lost counter saturation
      do_reset();
      for (int k = 0; k < 270; k++) begin
         step(200, 100, 1'b0);
         repeat (9) step(0, 100, 1'b0);
      end
      check("sat_lost", int'(lost_cnt), 255);
      check("sat_amp",  int'(out_amp),  200);
      check("sat_time", int'(out_time), 0);

      // randomized traffic
      do_reset();
      thr = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 97 == 0) thr = int'($urandom_range(0, 200)) - 100;
         if (i == 1500) do_reset();
         step((int'($urandom_range(0, 12)) - 6) * 50, thr, ($urandom_range(0, 3) == 0));
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
